mem_port_arbiter: RTL and testbench

Sequential arbiter sharing the single unified memory port between the instruction-fetch (IF) stage and the data-access (MEM) stage of the 5-stage pipelined RV32 core. It serialises at most one outstanding transaction and routes each response to its owner. It drives per-requester stall signals that the pipeline ORs into its existing load-use/branch stall path. A fairness counter bounds fetch starvation during back-to-back data accesses, and a fetch-kill input discards fetch responses made stale by a taken branch.

---
 rtl/core_pkg.sv | 15 +
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared types for the memory-port arbiter: FSM states and transaction owner.
package core_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_IF = 2'd1,
        WAIT_D  = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, one
// outstanding transaction at a time, with bounded fetch starvation and fetch kill.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | choose a winner, drive mem_req until mem_gnt
// WAIT_IF | fetch accepted, waiting for mem_rvalid (may be killed)
// WAIT_D  | load/store accepted, waiting for mem_rvalid
module mem_port_arbiter
    import core_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_kill,
    output logic                if_ack,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_stall,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic                d_ack,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_stall,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    arb_state_e       state_q;
    arb_state_e       state_d;
    logic [CNT_W-1:0] starve_cnt;
    logic             kill_q;
    owner_e           winner;
    logic             fetch_ok;
    logic             issue;
    logic             grant;
    logic             rsp;

    // A killed fetch never competes; a starved fetch beats a pending data access.
    always_comb begin
        fetch_ok = if_req & ~if_kill;
        if (fetch_ok && (!d_req || starve_cnt == CNT_MAX)) begin
            winner = OWN_IF;
        end else begin
            winner = OWN_D;
        end
    end

    assign issue = (state_q == IDLE) && !rst && (fetch_ok || d_req);
    assign grant = issue && mem_gnt;
    assign rsp   = (state_q != IDLE) && !rst && mem_rvalid;

    always_comb begin
        mem_req   = issue;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        if (issue) begin
            if (winner == OWN_IF) begin
                mem_addr = if_addr;
            end else begin
                mem_we    = d_we;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                mem_wstrb = d_wstrb;
            end
        end
    end

    // A kill arriving alongside the response squashes it as well.
    assign if_ack   = rsp && (state_q == WAIT_IF) && !kill_q && !if_kill;
    assign d_ack    = rsp && (state_q == WAIT_D);
    assign if_rdata = if_ack ? mem_rdata : '0;
    assign d_rdata  = d_ack ? mem_rdata : '0;
    assign if_stall = if_req & ~if_ack;
    assign d_stall  = d_req & ~d_ack;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = (winner == OWN_IF) ? WAIT_IF : WAIT_D;
                end
            end
            WAIT_IF, WAIT_D: begin
                if (mem_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            starve_cnt <= '0;
            kill_q     <= 1'b0;
        end else begin
            state_q <= state_d;

            if (!if_req || (grant && winner == OWN_IF)) begin
                starve_cnt <= '0;
            end else if (grant && starve_cnt != CNT_MAX) begin
                starve_cnt <= starve_cnt + 1'b1;
            end

            if (state_d == IDLE) begin
                kill_q <= 1'b0;
            end else if (if_kill && (state_q == WAIT_IF || (grant && winner == OWN_IF))) begin
                kill_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: two requesters, a memory with random
// grant/latency, a transaction-level reference model and a response scoreboard.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SM = 4;
    localparam int CYCLES_PER_PHASE = 1500;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, if_kill, if_ack, if_stall;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          d_req, d_we, d_ack, d_stall;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic [DW/8-1:0] d_wstrb;
    logic          mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [DW/8-1:0] mem_wstrb;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
        .if_ack(if_ack), .if_rdata(if_rdata), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    typedef struct {
        bit          is_f;
        bit          drop;
        bit          we;
        logic [31:0] data;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    // reference model: one transaction in flight, who owns it, starvation run length
    bit m_busy, m_own_f, m_own_we, m_kill;
    int m_starve;
    // memory and requester state
    bit mem_busy;
    int mem_delay;
    bit f_pend, d_pend, f_ack_seen, d_ack_seen;
    int phase, p_if, p_d, p_gnt, p_kill, p_dly;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d, phase %0d)", name, act, exp, cyc, phase);
        end
    endtask

    task automatic drive(input bit force_rst);
        rst = force_rst || ($urandom_range(249) == 0) ||
              (phase != 1 && m_busy && !m_own_f && $urandom_range(29) == 0);

        if (if_kill || f_ack_seen) f_pend = 1'b0;
        if (!f_pend && $urandom_range(99) < p_if) begin
            f_pend  = 1'b1;
            if_addr = $urandom() & 32'hFFFF_FFFC;
        end
        if_req  = f_pend;
        if_kill = ($urandom_range(99) < p_kill);

        if (d_ack_seen) d_pend = 1'b0;
        if (!d_pend && $urandom_range(99) < p_d) begin
            d_pend  = 1'b1;
            d_we    = 1'($urandom_range(1));
            d_addr  = $urandom() & 32'hFFFF_FFFC;
            d_wdata = $urandom();
            d_wstrb = d_we ? 4'($urandom_range(15)) : 4'h0;
        end
        d_req = d_pend;

        mem_gnt = ($urandom_range(99) < p_gnt);
        if (mem_busy) begin
            if (mem_delay == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = $urandom();
            end else begin
                mem_rvalid = 1'b0;
                mem_delay--;
            end
        end else begin
            mem_rvalid = ($urandom_range(99) < 5);
            mem_rdata  = $urandom();
        end
    endtask

    task automatic evaluate();
        bit   cf, win_f, exp_req, granted, exp_fack, exp_dack;
        rsp_t r;
        f_ack_seen = if_ack;
        d_ack_seen = d_ack;
        exp_fack   = 1'b0;
        exp_dack   = 1'b0;

        if (rst) begin
            check("reset_mem_req", mem_req, 0);
            m_busy = 0; m_starve = 0; m_kill = 0; mem_busy = 0;
        end else if (!m_busy) begin
            cf      = if_req && !if_kill;
            win_f   = cf && (!d_req || m_starve >= SM);
            exp_req = cf || d_req;
            check("mem_req", mem_req, exp_req);
            if (exp_req) begin
                check("mem_addr", mem_addr, win_f ? if_addr : d_addr);
                check("mem_we", mem_we, win_f ? 1'b0 : d_we);
                check("mem_wstrb", mem_wstrb, win_f ? 4'h0 : d_wstrb);
                if (!win_f) check("mem_wdata", mem_wdata, d_wdata);
            end
            granted = exp_req && mem_gnt;
            if (!if_req || (granted && win_f)) m_starve = 0;
            else if (granted && m_starve < SM) m_starve++;
            if (granted) begin
                m_busy   = 1;
                m_own_f  = win_f;
                m_own_we = !win_f && d_we;
                m_kill   = 0;
            end
        end else begin
            check("mem_req_busy", mem_req, 0);
            if (!if_req) m_starve = 0;
            if (mem_rvalid) begin
                r.is_f = m_own_f;
                r.drop = m_own_f && (m_kill || if_kill);
                r.we   = m_own_we;
                r.data = mem_rdata;
                exp_q.push_back(r);
                exp_fack = m_own_f && !r.drop;
                exp_dack = !m_own_f;
                m_busy = 0;
                m_kill = 0;
            end else if (m_own_f && if_kill) begin
                m_kill = 1;
            end
        end

        check("if_stall", if_stall, if_req && !exp_fack);
        check("d_stall", d_stall, d_req && !exp_dack);

        if (!rst) begin
            if (mem_busy && mem_rvalid) begin
                mem_busy = 0;
            end else if (!mem_busy && mem_req && mem_gnt) begin
                mem_busy  = 1;
                mem_delay = $urandom_range(p_dly);
            end
        end
    endtask

    // response monitor: pops what the model expected this cycle
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.is_f) begin
                    check("if_ack", if_ack, !e.drop);
                    check("d_ack_on_fetch", d_ack, 0);
                    if (!e.drop) check("if_rdata", if_rdata, e.data);
                end else begin
                    check("d_ack", d_ack, 1);
                    check("if_ack_on_data", if_ack, 0);
                    if (!e.we) check("d_rdata", d_rdata, e.data);
                end
            end else begin
                check("spurious_if_ack", if_ack, 0);
                check("spurious_d_ack", d_ack, 0);
            end
        end
    end

    initial begin
        rst = 1; if_req = 0; if_addr = '0; if_kill = 0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
        m_busy = 0; m_own_f = 0; m_own_we = 0; m_kill = 0; m_starve = 0;
        mem_busy = 0; mem_delay = 0;
        f_pend = 0; d_pend = 0; f_ack_seen = 0; d_ack_seen = 0;

        for (int ph = 0; ph < 4; ph++) begin
            phase = ph;
            case (ph)
                0: begin p_if = 50;  p_d = 50;  p_gnt = 70;  p_kill = 5;  p_dly = 3; end
                1: begin p_if = 100; p_d = 100; p_gnt = 100; p_kill = 0;  p_dly = 0; end
                2: begin p_if = 70;  p_d = 40;  p_gnt = 60;  p_kill = 25; p_dly = 3; end
                default: begin p_if = 40; p_d = 60; p_gnt = 20; p_kill = 3; p_dly = 2; end
            endcase
            for (int c = 0; c < CYCLES_PER_PHASE; c++) begin
                @(posedge clk);
                #1;
                cyc++;
                drive(ph == 0 && c < 3);
                @(negedge clk);
                evaluate();
            end
        end

        @(negedge clk);
        #5;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
